cpu_sequencer: RTL and testbench

Parametrised cycle sequencer for the 6502 core: owns the per-instruction step counter, the fetch/sync marker, and the reset/NMI/IRQ entry sequences. Sits between the pin-level control inputs (rdy, nmi, irq, so) and the instruction decoder. The decoder consumes `step` and `seq_kind` to drive the bus control lines, and returns `done` on the last cycle of each opcode.

---
 rtl/cpu_sequencer.sv | 153 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Cycle sequencer for the 6502 core: step counter, fetch marker and reset/NMI/IRQ entry.
// State advances on the falling clock edge; every output is decoded from registers only.
module cpu_sequencer #(
  parameter int unsigned STEP_W    = 3,
  parameter int unsigned RST_STEPS = 7,
  parameter int unsigned INT_STEPS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              nmi,
  input  logic              irq,
  input  logic              so,
  input  logic              i_flag,
  input  logic              done,
  output logic [STEP_W-1:0] step,
  output logic              sync,
  output logic [1:0]        seq_kind,
  output logic [7:0]        vec_lo,
  output logic              nmi_pending,
  output logic              so_set,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    KindNormal = 2'b00,
    KindIrq    = 2'b01,
    KindNmi    = 2'b10,
    KindReset  = 2'b11
  } kind_e;

  typedef logic [STEP_W:0] cnt_t;

  localparam cnt_t              RstLast = cnt_t'(RST_STEPS - 1);
  localparam cnt_t              IntLast = cnt_t'(INT_STEPS - 1);
  localparam logic [STEP_W-1:0] StepMax = '1;

  kind_e             r_kind;
  kind_e             w_kind_d;
  kind_e             w_boundary_kind;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_d;
  logic              r_armed;
  logic              r_nmi_prev;
  logic              r_so_prev;
  logic              r_nmi_pending;
  logic              r_so_set;
  logic              r_seq_err;
  logic              w_nmi_pending_d;
  logic              w_seq_err_d;
  logic              w_nmi_edge;
  logic              w_so_edge;
  logic              w_advance;
  logic              w_last;
  logic              w_overflow;
  logic              w_enter_nmi;

  assign w_nmi_edge = nmi & ~r_nmi_prev;
  assign w_so_edge  = so & ~r_so_prev;
  // The first edge after reset release only arms the sequencer, so the reset
  // sequence always starts from a clean, edge-aligned step 0.
  assign w_advance  = r_armed & rdy;

  // Sequence selection at a boundary; a fresh NMI edge on this very edge counts.
  always_comb begin
    w_boundary_kind = KindNormal;
    if (r_nmi_pending || w_nmi_edge) begin
      w_boundary_kind = KindNmi;
    end else if (irq && !i_flag) begin
      w_boundary_kind = KindIrq;
    end
  end

  always_comb begin
    w_last     = 1'b0;
    w_overflow = 1'b0;
    case (r_kind)
      KindReset: w_last = ({1'b0, r_step} == RstLast);
      KindIrq,
      KindNmi:   w_last = ({1'b0, r_step} == IntLast);
      default: begin
        w_overflow = (r_step == StepMax) && !done;
        w_last     = done || (r_step == StepMax);
      end
    endcase
  end

  always_comb begin
    w_step_d    = r_step;
    w_kind_d    = r_kind;
    w_enter_nmi = 1'b0;
    w_seq_err_d = r_seq_err;
    if (w_advance) begin
      if (w_last) begin
        w_step_d    = '0;
        w_kind_d    = w_boundary_kind;
        w_enter_nmi = (w_boundary_kind == KindNmi);
      end else begin
        w_step_d = r_step + 1'b1;
      end
      if (w_overflow) begin
        w_seq_err_d = 1'b1;
      end
    end
    // Entering NMI consumes the latched request; only a new edge arriving on
    // top of an already-latched one survives the clear.
    if (w_enter_nmi) begin
      w_nmi_pending_d = r_nmi_pending & w_nmi_edge;
    end else begin
      w_nmi_pending_d = r_nmi_pending | w_nmi_edge;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step        <= '0;
      r_kind        <= KindReset;
      r_armed       <= 1'b0;
      r_nmi_prev    <= 1'b0;
      r_so_prev     <= 1'b0;
      r_nmi_pending <= 1'b0;
      r_so_set      <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_step        <= w_step_d;
      r_kind        <= w_kind_d;
      r_armed       <= 1'b1;
      r_nmi_prev    <= nmi;
      r_so_prev     <= so;
      r_nmi_pending <= w_nmi_pending_d;
      r_so_set      <= w_so_edge;
      r_seq_err     <= w_seq_err_d;
    end
  end

  always_comb begin
    vec_lo = 8'h00;
    case (r_kind)
      KindReset: vec_lo = 8'hFC;
      KindNmi:   vec_lo = 8'hFA;
      KindIrq:   vec_lo = 8'hFE;
      default:   vec_lo = 8'h00;
    endcase
  end

  assign step        = r_step;
  assign seq_kind    = r_kind;
  assign sync        = (r_kind == KindNormal) && (r_step == '0);
  assign nmi_pending = r_nmi_pending;
  assign so_set      = r_so_set;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized stimulus against a
// cycle-level behavioural model of the sequencing rules.
module tb_cpu_sequencer;

  localparam int STEP_W    = 3;
  localparam int RST_STEPS = 7;
  localparam int INT_STEPS = 7;
  localparam int MAX_STEP  = (1 << STEP_W) - 1;
  localparam int K_NORMAL  = 0;
  localparam int K_IRQ     = 1;
  localparam int K_NMI     = 2;
  localparam int K_RESET   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0, nmi = 1'b0, irq = 1'b0, so = 1'b0, i_flag = 1'b0, done = 1'b0;
  logic [STEP_W-1:0] step;
  logic              sync;
  logic [1:0]        seq_kind;
  logic [7:0]        vec_lo;
  logic              nmi_pending, so_set, seq_err;
  logic [16:0]       obs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   m_step, m_kind;
  bit   m_pend, m_so_set, m_err, m_armed, m_nmi_prev, m_so_prev;
  logic [7:0] vec_of [4] = '{8'h00, 8'hFE, 8'hFA, 8'hFC};

  cpu_sequencer #(
    .STEP_W   (STEP_W),
    .RST_STEPS(RST_STEPS),
    .INT_STEPS(INT_STEPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .nmi        (nmi),
    .irq        (irq),
    .so         (so),
    .i_flag     (i_flag),
    .done       (done),
    .step       (step),
    .sync       (sync),
    .seq_kind   (seq_kind),
    .vec_lo     (vec_lo),
    .nmi_pending(nmi_pending),
    .so_set     (so_set),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  assign obs = {step, sync, seq_kind, vec_lo, nmi_pending, so_set, seq_err};

  function automatic logic [16:0] model_vec();
    logic [2:0] s;
    logic [1:0] k;
    s = 3'(m_step);
    k = 2'(m_kind);
    return {s, (m_kind == K_NORMAL && m_step == 0), k, vec_of[m_kind], m_pend, m_so_set, m_err};
  endfunction

  task automatic model_reset();
    m_step = 0; m_kind = K_RESET; m_pend = 0; m_so_set = 0; m_err = 0;
    m_armed = 0; m_nmi_prev = 0; m_so_prev = 0;
  endtask

  // One falling edge of the sequencing rules, from the inputs currently applied.
  task automatic model_edge();
    bit ne, se, last;
    int len;
    if (!rst_n) return;
    ne = nmi && !m_nmi_prev;
    se = so && !m_so_prev;
    m_nmi_prev = nmi;
    m_so_prev  = so;
    m_so_set   = se;
    if (!m_armed || !rdy) begin
      m_armed = 1;
      m_pend  = m_pend || ne;
      return;
    end
    len = (m_kind == K_RESET) ? RST_STEPS : INT_STEPS;
    if (m_kind == K_NORMAL) last = done || (m_step == MAX_STEP);
    else                    last = (m_step == len - 1);
    if (m_kind == K_NORMAL && m_step == MAX_STEP && !done) m_err = 1;
    if (!last) begin
      m_step++;
      m_pend = m_pend || ne;
    end else begin
      m_step = 0;
      if (m_pend || ne) begin
        m_kind = K_NMI;
        m_pend = m_pend && ne;
      end else begin
        m_kind = (irq && !i_flag) ? K_IRQ : K_NORMAL;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; rdy = 1; nmi = 0; irq = 0; so = 0; i_flag = 0; done = 0;
    model_reset();
    tick(); tick();
    checks++;
    if (obs !== {3'd0, 1'b0, 2'b11, 8'hFC, 3'b000}) begin
      errors++; $display("FAIL reset_values: got %h want %h", obs, {3'd0, 1'b0, 2'b11, 8'hFC, 3'b000});
    end
    rst_n = 1;
    for (int k = 1; k <= RST_STEPS; k++) begin
      tick();
      checks++;
      if ({step, seq_kind, vec_lo} !== {3'(k - 1), 2'b11, 8'hFC}) begin
        errors++;
        $display("FAIL reset_seq[%0d]: got step %0d kind %0d vec %h want step %0d kind 3 vec fc",
                 k, step, seq_kind, vec_lo, k - 1);
      end
    end
    tick();
    checks++;
    if ({step, seq_kind, sync} !== {3'd0, 2'b00, 1'b1}) begin
      errors++; $display("FAIL first_fetch: got step %0d kind %0d sync %b want 0 0 1", step, seq_kind, sync);
    end
  endtask

  task automatic test_normal_stall();
    done = 0; rdy = 1;
    tick(); tick();
    rdy = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (step !== 3'd2) begin
        errors++; $display("FAIL stall_hold[%0d]: got step %0d want 2", k, step);
      end
    end
    rdy = 1;
    tick();
    checks++;
    if (step !== 3'd3) begin
      errors++; $display("FAIL stall_resume: got step %0d want 3", step);
    end
    done = 1;
    tick();
    done = 0;
    checks++;
    if ({step, seq_kind, sync} !== {3'd0, 2'b00, 1'b1}) begin
      errors++; $display("FAIL done_boundary: got step %0d kind %0d sync %b want 0 0 1", step, seq_kind, sync);
    end
  endtask

  task automatic test_nmi_over_irq();
    tick();
    nmi = 1; irq = 1; i_flag = 0;
    tick();
    checks++;
    if ({step, nmi_pending} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL nmi_latch: got step %0d pend %b want 2 1", step, nmi_pending);
    end
    nmi = 0; done = 1;
    tick();
    done = 0;
    checks++;
    if ({step, seq_kind, vec_lo, nmi_pending} !== {3'd0, 2'b10, 8'hFA, 1'b0}) begin
      errors++; $display("FAIL nmi_entry: got step %0d kind %0d vec %h pend %b want 0 2 fa 0",
                         step, seq_kind, vec_lo, nmi_pending);
    end
    repeat (INT_STEPS - 1) tick();
    checks++;
    if ({step, seq_kind} !== {3'(INT_STEPS - 1), 2'b10}) begin
      errors++; $display("FAIL nmi_last: got step %0d kind %0d want %0d 2", step, seq_kind, INT_STEPS - 1);
    end
    tick();
    checks++;
    if ({step, seq_kind, vec_lo} !== {3'd0, 2'b01, 8'hFE}) begin
      errors++; $display("FAIL irq_after_nmi: got step %0d kind %0d vec %h want 0 1 fe", step, seq_kind, vec_lo);
    end
    irq = 0;
    repeat (INT_STEPS) tick();
    checks++;
    if ({step, seq_kind, sync} !== {3'd0, 2'b00, 1'b1}) begin
      errors++; $display("FAIL irq_exit: got step %0d kind %0d sync %b want 0 0 1", step, seq_kind, sync);
    end
  endtask

  task automatic test_irq_mask();
    irq = 1; i_flag = 1; done = 1;
    tick();
    checks++;
    if ({step, seq_kind} !== {3'd0, 2'b00}) begin
      errors++; $display("FAIL irq_masked: got step %0d kind %0d want 0 0", step, seq_kind);
    end
    i_flag = 0; done = 0;
    tick();
    done = 1;
    tick();
    checks++;
    if ({step, seq_kind, vec_lo} !== {3'd0, 2'b01, 8'hFE}) begin
      errors++; $display("FAIL irq_unmasked: got step %0d kind %0d vec %h want 0 1 fe", step, seq_kind, vec_lo);
    end
    irq = 0; done = 0;
    repeat (INT_STEPS) tick();
  endtask

  task automatic test_overflow();
    done = 0;
    repeat (MAX_STEP) tick();
    checks++;
    if ({step, seq_err} !== {3'(MAX_STEP), 1'b0}) begin
      errors++; $display("FAIL pre_wrap: got step %0d err %b want %0d 0", step, seq_err, MAX_STEP);
    end
    tick();
    checks++;
    if ({step, seq_kind, sync, seq_err} !== {3'd0, 2'b00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wrap: got step %0d kind %0d sync %b err %b want 0 0 1 1",
                         step, seq_kind, sync, seq_err);
    end
    irq = 1; i_flag = 0; done = 1;
    tick();
    irq = 0; done = 0;
    repeat (INT_STEPS) tick();
    checks++;
    if ({seq_kind, seq_err} !== {2'b00, 1'b1}) begin
      errors++; $display("FAIL err_sticky: got kind %0d err %b want 0 1", seq_kind, seq_err);
    end
  endtask

  task automatic test_so_and_reset();
    rdy = 0; so = 1;
    tick();
    checks++;
    if ({so_set, step} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL so_pulse: got so_set %b step %0d want 1 0", so_set, step);
    end
    tick();
    checks++;
    if (so_set !== 1'b0) begin
      errors++; $display("FAIL so_one_cycle: got so_set %b want 0", so_set);
    end
    so = 0; rdy = 1;
    tick();
    nmi = 1;
    tick();
    nmi = 0; done = 1;
    tick();
    done = 0;
    tick();
    nmi = 1;
    tick();
    nmi = 0;
    tick(); tick();
    checks++;
    if ({step, seq_kind, nmi_pending} !== {3'd4, 2'b10, 1'b1}) begin
      errors++; $display("FAIL nmi_step4: got step %0d kind %0d pend %b want 4 2 1", step, seq_kind, nmi_pending);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== {3'd0, 1'b0, 2'b11, 8'hFC, 3'b000}) begin
      errors++; $display("FAIL midseq_reset: got %h want %h", obs, {3'd0, 1'b0, 2'b11, 8'hFC, 3'b000});
    end
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rdy    = ($urandom_range(0, 7) != 0);
      done   = ($urandom_range(0, 3) == 0);
      nmi    = ($urandom_range(0, 5) == 0);
      irq    = ($urandom_range(0, 2) == 0);
      i_flag = 1'($urandom_range(0, 1));
      so     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== model_vec()) begin
          errors++; $display("FAIL random_reset[%0d]: got %h want %h", i, obs, model_vec());
        end
        rst_n = 1;
      end
      tick();
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_stall();
    test_nmi_over_irq();
    test_irq_mask();
    test_overflow();
    test_so_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
